// File: rtl/sodor_state_scan_pkg.sv
// Shared widths, region numbering and FSM encoding for the Sodor two-copy state scan.
package sodor_state_scan_pkg;
    localparam int REGION_W = 4;
    localparam int INDEX_W  = 8;
    localparam int COUNT_W  = 16;

    localparam logic [REGION_W-1:0] REGION_RF       = 4'd0;
    localparam logic [REGION_W-1:0] REGION_CSR      = 4'd1;
    localparam logic [REGION_W-1:0] REGION_MEM_BASE = 4'd2;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + COUNT_W'(1);
    endfunction
endpackage

// File: rtl/sodor_state_scan_addr.sv
// Region/index walker for the flat scan order: RF, CSR, then each memory bank.
module sodor_state_scan_addr
    import sodor_state_scan_pkg::*;
#(
    parameter int RF_WORDS  = 32,
    parameter int CSR_WORDS = 16,
    parameter int MEM_BANKS = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    input  logic                adv,
    output logic [REGION_W-1:0] region,
    output logic [INDEX_W-1:0]  index,
    output logic                last
);
    localparam logic [REGION_W-1:0] LAST_REGION = REGION_MEM_BASE + REGION_W'(MEM_BANKS - 1);

    logic [REGION_W-1:0] region_q, region_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [INDEX_W-1:0]  limit;

    always_comb begin
        limit = INDEX_W'(MEM_WORDS - 1);
        if (region_q == REGION_RF) begin
            limit = INDEX_W'(RF_WORDS - 1);
        end else if (region_q == REGION_CSR) begin
            limit = INDEX_W'(CSR_WORDS - 1);
        end
    end

    assign last = (region_q == LAST_REGION) && (index_q == INDEX_W'(MEM_WORDS - 1));

    always_comb begin
        region_d = region_q;
        index_d  = index_q;
        if (clr) begin
            region_d = REGION_RF;
            index_d  = '0;
        end else if (adv && !last) begin
            if (index_q == limit) begin
                region_d = region_q + REGION_W'(1);
                index_d  = '0;
            end else begin
                index_d = index_q + INDEX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            region_q <= REGION_RF;
            index_q  <= '0;
        end else begin
            region_q <= region_d;
            index_q  <= index_d;
        end
    end

    assign region = region_q;
    assign index  = index_q;
endmodule

// File: rtl/sodor_state_scan_ctrl.sv
// Scan sequencer: reads every architectural word from both copies, compares the
// returned pairs one cycle later and keeps first-mismatch location and count.
module sodor_state_scan_ctrl
    import sodor_state_scan_pkg::*;
#(
    parameter int RF_WORDS  = 32,
    parameter int CSR_WORDS = 16,
    parameter int MEM_BANKS = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 stop_on_first,
    input  logic [CSR_WORDS-1:0] csr_cmp_mask,
    output logic                 rd_en,
    output logic [REGION_W-1:0]  rd_region,
    output logic [INDEX_W-1:0]   rd_index,
    input  logic [31:0]          src_rdata,
    input  logic [31:0]          tgt_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [REGION_W-1:0]  first_region,
    output logic [INDEX_W-1:0]   first_index,
    output logic [COUNT_W-1:0]   mismatch_count
);
    localparam int CSR_IDX_W = $clog2(CSR_WORDS);

    scan_state_e          state_q, state_d;
    logic                 rd_en_q, rd_en_d;
    logic                 sof_q, sof_d;
    logic [CSR_WORDS-1:0] mask_q, mask_d;
    logic                 mismatch_q, mismatch_d;
    logic [REGION_W-1:0]  first_region_q, first_region_d;
    logic [INDEX_W-1:0]   first_index_q, first_index_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 vld_p1_q;
    logic [REGION_W-1:0]  region_p1_q;
    logic [INDEX_W-1:0]   index_p1_q;

    logic                 addr_clr, addr_adv, addr_last;
    logic [REGION_W-1:0]  addr_region;
    logic [INDEX_W-1:0]   addr_index;
    logic                 cmp_en, pair_diff;

    sodor_state_scan_addr #(
        .RF_WORDS  (RF_WORDS),
        .CSR_WORDS (CSR_WORDS),
        .MEM_BANKS (MEM_BANKS),
        .MEM_WORDS (MEM_WORDS)
    ) u_addr (
        .clock  (clock),
        .reset  (reset),
        .clr    (addr_clr),
        .adv    (addr_adv),
        .region (addr_region),
        .index  (addr_index),
        .last   (addr_last)
    );

    // Compare stage (p1): qualifier follows the read strobe by one cycle; only live in SCAN/DRAIN
    // so that a stop or abort discards whatever read was still in flight.
    always_comb begin
        cmp_en = vld_p1_q && ((state_q == SCAN) || (state_q == DRAIN));
        if ((region_p1_q == REGION_CSR) && !mask_q[index_p1_q[CSR_IDX_W-1:0]]) begin
            cmp_en = 1'b0;
        end
        pair_diff = cmp_en && (src_rdata != tgt_rdata);
    end

    always_comb begin
        state_d        = state_q;
        rd_en_d        = 1'b0;
        addr_clr       = 1'b0;
        addr_adv       = 1'b0;
        sof_d          = sof_q;
        mask_d         = mask_q;
        mismatch_d     = mismatch_q;
        first_region_d = first_region_q;
        first_index_d  = first_index_q;
        count_d        = count_q;

        if (pair_diff) begin
            mismatch_d = 1'b1;
            count_d    = sat_inc(count_q);
            if (!mismatch_q) begin
                first_region_d = region_p1_q;
                first_index_d  = index_p1_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = SCAN;
                    rd_en_d        = 1'b1;
                    addr_clr       = 1'b1;
                    sof_d          = stop_on_first;
                    mask_d         = csr_cmp_mask;
                    mismatch_d     = 1'b0;
                    first_region_d = '0;
                    first_index_d  = '0;
                    count_d        = '0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (pair_diff && sof_q) begin
                    state_d = DONE;
                end else if (addr_last) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d  = 1'b1;
                    addr_adv = 1'b1;
                end
            end
            DRAIN: begin
                state_d = abort ? IDLE : DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            rd_en_q        <= 1'b0;
            vld_p1_q       <= 1'b0;
            mismatch_q     <= 1'b0;
            first_region_q <= '0;
            first_index_q  <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            vld_p1_q       <= rd_en_q;
            mismatch_q     <= mismatch_d;
            first_region_q <= first_region_d;
            first_index_q  <= first_index_d;
            count_q        <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        sof_q       <= sof_d;
        mask_q      <= mask_d;
        region_p1_q <= addr_region;
        index_p1_q  <= addr_index;
    end

    assign rd_en          = rd_en_q;
    assign rd_region      = addr_region;
    assign rd_index       = addr_index;
    assign busy           = (state_q == SCAN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign mismatch       = mismatch_q;
    assign first_region   = first_region_q;
    assign first_index    = first_index_q;
    assign mismatch_count = count_q;
endmodule

// File: tb/tb_sodor_state_scan_ctrl.sv
// Directed-plus-random bench for sodor_state_scan_ctrl with a flat-order reference model.
module tb_sodor_state_scan_ctrl;
    localparam int RF_WORDS  = 32;
    localparam int CSR_WORDS = 16;
    localparam int MEM_BANKS = 8;
    localparam int MEM_WORDS = 256;
    localparam int W = RF_WORDS + CSR_WORDS + MEM_BANKS * MEM_WORDS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        stop_on_first = 1'b0;
    logic [15:0] csr_cmp_mask = 16'hFFFF;
    logic        rd_en;
    logic [3:0]  rd_region;
    logic [7:0]  rd_index;
    logic [31:0] src_rdata = '0;
    logic [31:0] tgt_rdata = '0;
    logic        busy, done, mismatch;
    logic [3:0]  first_region;
    logic [7:0]  first_index;
    logic [15:0] mismatch_count;

    int total = 0;
    int bad = 0;

    logic [31:0] src_mem  [W];
    logic [31:0] flip_mem [W];
    logic        resp_en;
    int          resp_f;

    always #5 clk = ~clk;

    sodor_state_scan_ctrl #(
        .RF_WORDS(RF_WORDS), .CSR_WORDS(CSR_WORDS), .MEM_BANKS(MEM_BANKS), .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clock(clk), .reset(reset), .start(start), .abort(abort),
        .stop_on_first(stop_on_first), .csr_cmp_mask(csr_cmp_mask),
        .rd_en(rd_en), .rd_region(rd_region), .rd_index(rd_index),
        .src_rdata(src_rdata), .tgt_rdata(tgt_rdata),
        .busy(busy), .done(done), .mismatch(mismatch),
        .first_region(first_region), .first_index(first_index),
        .mismatch_count(mismatch_count)
    );

    function automatic int addr_to_flat(input logic [3:0] r, input logic [7:0] i);
        if (r == 4'd0) return int'(i);
        if (r == 4'd1) return RF_WORDS + int'(i);
        return RF_WORDS + CSR_WORDS + (int'(r) - 2) * MEM_WORDS + int'(i);
    endfunction

    function automatic logic [3:0] flat_region(input int k);
        if (k < RF_WORDS) return 4'd0;
        if (k < RF_WORDS + CSR_WORDS) return 4'd1;
        return 4'(2 + (k - RF_WORDS - CSR_WORDS) / MEM_WORDS);
    endfunction

    function automatic logic [7:0] flat_index(input int k);
        if (k < RF_WORDS) return 8'(k);
        if (k < RF_WORDS + CSR_WORDS) return 8'(k - RF_WORDS);
        return 8'((k - RF_WORDS - CSR_WORDS) % MEM_WORDS);
    endfunction

    // Both state copies: data appears the cycle after the read strobe, junk otherwise.
    always @(posedge clk) begin
        resp_en = rd_en;
        resp_f  = addr_to_flat(rd_region, rd_index);
        #1;
        if (resp_en && resp_f >= 0 && resp_f < W) begin
            src_rdata = src_mem[resp_f];
            tgt_rdata = src_mem[resp_f] ^ flip_mem[resp_f];
        end else begin
            src_rdata = $urandom;
            tgt_rdata = $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_flips();
        for (int k = 0; k < W; k++) flip_mem[k] = '0;
    endtask

    task automatic set_flip(input int k);
        flip_mem[k] = 32'h1 << $urandom_range(31, 0);
    endtask

    task automatic model(input logic sof, input logic [15:0] mask,
                         output logic emm, output logic [3:0] efr, output logic [7:0] efi,
                         output int ecnt, output int edone, output int ereads);
        emm = 1'b0; efr = '0; efi = '0; ecnt = 0; edone = W + 2; ereads = W;
        for (int k = 0; k < W; k++) begin
            if (k >= RF_WORDS && k < RF_WORDS + CSR_WORDS && !mask[k - RF_WORDS]) continue;
            if (flip_mem[k] != 0) begin
                if (!emm) begin
                    efr = flat_region(k);
                    efi = flat_index(k);
                end
                emm = 1'b1;
                ecnt++;
                if (sof) begin
                    edone  = k + 3;
                    ereads = (k + 2 < W) ? k + 2 : W;
                    break;
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_region"}, 32'(rd_region), 0);
        chk({tag, "_rd_index"}, 32'(rd_index), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_mismatch"}, 32'(mismatch), 0);
        chk({tag, "_first_region"}, 32'(first_region), 0);
        chk({tag, "_first_index"}, 32'(first_index), 0);
        chk({tag, "_count"}, 32'(mismatch_count), 0);
    endtask

    task automatic run_scan(input logic sof, input logic [15:0] mask, input string tag);
        logic       emm;
        logic [3:0] efr;
        logic [7:0] efi;
        int ecnt, edone, ereads, cyc, reads, addr_err, done_cyc;
        model(sof, mask, emm, efr, efi, ecnt, edone, ereads);
        @(negedge clk);
        stop_on_first = sof;
        csr_cmp_mask  = mask;
        start         = 1'b1;
        @(posedge clk); #1;
        start         = 1'b0;
        stop_on_first = ~sof;
        csr_cmp_mask  = ~mask;
        cyc = 1; reads = 0; addr_err = 0; done_cyc = -1;
        while (cyc <= W + 10) begin
            if (rd_en) begin
                if (reads >= W || cyc != reads + 1 ||
                    rd_region !== flat_region(reads) || rd_index !== flat_index(reads))
                    addr_err++;
                reads++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(edone));
        chk({tag, "_reads"}, 32'(reads), 32'(ereads));
        chk({tag, "_addr_order"}, 32'(addr_err), 0);
        chk({tag, "_busy_at_done"}, 32'(busy), 0);
        chk({tag, "_mismatch"}, 32'(mismatch), 32'(emm));
        chk({tag, "_first_region"}, 32'(first_region), 32'(efr));
        chk({tag, "_first_index"}, 32'(first_index), 32'(efi));
        chk({tag, "_count"}, 32'(mismatch_count), 32'(ecnt));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_rd_en_after"}, 32'(rd_en), 0);
        chk({tag, "_count_hold"}, 32'(mismatch_count), 32'(ecnt));
    endtask

    initial begin
        int cyc;
        int seen;
        int n;
        for (int k = 0; k < W; k++) src_mem[k] = $urandom;
        clear_flips();

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // abort while idle must not disturb anything
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);

        run_scan(1'b0, 16'hFFFF, "all_equal");

        clear_flips();
        set_flip(addr_to_flat(4'd0, 8'd5));
        run_scan(1'b1, 16'hFFFF, "rf5_stop");

        clear_flips();
        set_flip(addr_to_flat(4'd5, 8'd0));
        set_flip(addr_to_flat(4'd9, 8'd255));
        run_scan(1'b0, 16'hFFFF, "mem_two");

        clear_flips();
        set_flip(addr_to_flat(4'd1, 8'd2));
        run_scan(1'b0, 16'hFFFB, "csr2_masked");
        run_scan(1'b0, 16'hFFFF, "csr2_compared");

        clear_flips();
        set_flip(W - 1);
        run_scan(1'b1, 16'hFFFF, "last_word_stop");

        clear_flips();
        set_flip(W - 2);
        run_scan(1'b1, 16'hFFFF, "second_last_stop");

        for (int it = 0; it < 4; it++) begin
            clear_flips();
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) set_flip($urandom_range(W - 1, 0));
            if (it == 0) set_flip($urandom_range(RF_WORDS + CSR_WORDS - 1, RF_WORDS));
            run_scan(1'($urandom_range(1, 0)), 16'($urandom), $sformatf("rand%0d", it));
        end

        // abort at cycle 100 with start held high through the early scan
        clear_flips();
        @(negedge clk);
        stop_on_first = 1'b0;
        csr_cmp_mask  = 16'hFFFF;
        start         = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_busy50", 32'(busy), 1);
        chk("abort_region50", 32'(rd_region), 2);
        chk("abort_index50", 32'(rd_index), 1);
        start = 1'b0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy101", 32'(busy), 0);
        chk("abort_rd_en101", 32'(rd_en), 0);
        chk("abort_done101", 32'(done), 0);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 0);

        // reset at cycle 50 after a mismatch has already been recorded
        clear_flips();
        set_flip(addr_to_flat(4'd0, 8'd3));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("pre_reset_mismatch", 32'(mismatch), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("midreset");
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("midreset_no_done", 32'(seen), 0);

        clear_flips();
        run_scan(1'b0, 16'hFFFF, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
